// File: rtl/key_event_detect.sv
// Key event classifier: turns a clean key level into short-press,
// double-click, long-press and auto-repeat pulses plus a held level.
module key_event_detect #(
    parameter int unsigned LONG_CYC   = 50_000_000,
    parameter int unsigned DBL_CYC    = 15_000_000,
    parameter int unsigned REPEAT_CYC = 10_000_000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic key_held
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_WAIT2  = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_LONG   = 3'd4;

    // Terminal counter values; each counting state exits or reloads here.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             key_d_q;
    logic             short_q, short_d;
    logic             dbl_q, dbl_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;
    logic             held_q, held_d;
    logic             rise_c, fall_c;

    // Input is already synchronous, so a single delay stage gives the edges.
    assign rise_c = key_in & ~key_d_q;
    assign fall_c = ~key_in & key_d_q;

    // Next-state, counter and pulse decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        short_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_c) begin
                    state_d = ST_PRESS1;
                    cnt_d   = '0;
                end
            end
            ST_PRESS1: begin
                if (fall_c) begin
                    state_d = ST_WAIT2;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    rcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT2: begin
                // A rise on the timeout edge still counts as the second press.
                if (rise_c) begin
                    state_d = ST_PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q == DBL_LAST) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESS2: begin
                if (fall_c) begin
                    state_d = ST_IDLE;
                    dbl_d   = 1'b1;
                end
            end
            ST_LONG: begin
                // Release suppresses a repeat due on the same edge.
                if (fall_c) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q == REP_LAST) begin
                    rep_d  = 1'b1;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                rcnt_d  = '0;
            end
        endcase
        held_d = (state_d == ST_LONG);
    end

    // State, counters, edge delay and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            key_d_q <= 1'b0;
            short_q <= 1'b0;
            dbl_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            key_d_q <= key_in;
            short_q <= short_d;
            dbl_q   <= dbl_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            held_q  <= held_d;
        end
    end

    assign short_press  = short_q;
    assign double_click = dbl_q;
    assign long_press   = long_q;
    assign repeat_pulse = rep_q;
    assign key_held     = held_q;

endmodule

// File: tb/tb_key_event_detect.sv
// Bench for key_event_detect: directed scenarios plus random key traffic,
// compared every cycle against a timestamp-based reference model.
module tb_key_event_detect;

    localparam int LONG = 20;
    localparam int DBL  = 8;
    localparam int REP  = 5;
    localparam int CW   = 5;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic key_in;
    logic short_press, double_click, long_press, repeat_pulse, key_held;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: sequence tracked by edge timestamps.
    int edge_n = 0;
    int t_rise, t_fall;
    bit m_prev, m_active, m_have_fall, m_second, m_long;

    int c_short, c_dbl, c_long, c_rep;

    key_event_detect #(
        .LONG_CYC  (LONG),
        .DBL_CYC   (DBL),
        .REPEAT_CYC(REP),
        .CNT_W     (CW)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_in      (key_in),
        .short_press (short_press),
        .double_click(double_click),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse),
        .key_held    (key_held)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // Advance the model by one clock edge with key level k.
    task automatic model_step(input logic k, output logic [4:0] e);
        bit rise, fall;
        bit es, ed, el, er;
        es = 0; ed = 0; el = 0; er = 0;
        edge_n++;
        rise = k && !m_prev;
        fall = !k && m_prev;
        if (!m_active) begin
            if (rise) begin
                m_active = 1; t_rise = edge_n;
                m_have_fall = 0; m_second = 0; m_long = 0;
            end
        end else if (m_second) begin
            if (fall) begin ed = 1; m_active = 0; end
        end else if (m_long) begin
            if (fall) m_active = 0;
            else if ((edge_n - t_rise - LONG) % REP == 0) er = 1;
        end else if (!m_have_fall) begin
            if (fall) begin m_have_fall = 1; t_fall = edge_n; end
            else if (edge_n - t_rise == LONG) begin m_long = 1; el = 1; end
        end else begin
            if (rise) m_second = 1;
            else if (edge_n - t_fall == DBL) begin es = 1; m_active = 0; end
        end
        m_prev = k;
        e = {es, ed, el, er, (m_active && m_long)};
    endtask

    // Drive one cycle of key level, then compare all outputs after the edge.
    task automatic tick(input logic k);
        logic [4:0] e;
        key_in = k;
        @(posedge sys_clk);
        model_step(k, e);
        #1;
        check("short_press",  32'(short_press),  32'(e[4]));
        check("double_click", 32'(double_click), 32'(e[3]));
        check("long_press",   32'(long_press),   32'(e[2]));
        check("repeat_pulse", 32'(repeat_pulse), 32'(e[1]));
        check("key_held",     32'(key_held),     32'(e[0]));
        check("pulse_onehot", 32'($countones({short_press, double_click, long_press, repeat_pulse}) <= 1), 32'(1));
        c_short += int'(short_press);
        c_dbl   += int'(double_click);
        c_long  += int'(long_press);
        c_rep   += int'(repeat_pulse);
    endtask

    task automatic press(input int hi, input int lo);
        repeat (hi) tick(1'b1);
        repeat (lo) tick(1'b0);
    endtask

    task automatic clear_counts();
        c_short = 0; c_dbl = 0; c_long = 0; c_rep = 0;
    endtask

    task automatic check_counts(input string tag, input int s, input int d, input int l, input int r);
        check({tag, "_n_short"},  32'(c_short), 32'(s));
        check({tag, "_n_double"}, 32'(c_dbl),   32'(d));
        check({tag, "_n_long"},   32'(c_long),  32'(l));
        check({tag, "_n_repeat"}, 32'(c_rep),   32'(r));
    endtask

    // Assert reset mid-cycle, verify outputs clear without a clock, release after an edge.
    task automatic do_reset(input logic k_during);
        #2;
        sys_rst_n = 1'b0;
        key_in    = k_during;
        #1;
        check("rst_short",  32'(short_press),  32'(0));
        check("rst_double", 32'(double_click), 32'(0));
        check("rst_long",   32'(long_press),   32'(0));
        check("rst_repeat", 32'(repeat_pulse), 32'(0));
        check("rst_held",   32'(key_held),     32'(0));
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        m_prev = 0; m_active = 0; m_long = 0; m_second = 0; m_have_fall = 0;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        key_in    = 1'b0;
        clear_counts();

        // Power-on reset and idle
        do_reset(1'b0);
        repeat (3) tick(1'b0);

        // Single short press
        clear_counts();
        press(5, 12);
        check_counts("short", 1, 0, 0, 0);

        // Double click
        clear_counts();
        press(3, 4);
        press(3, 12);
        check_counts("double", 0, 1, 0, 0);

        // Long press with two repeats, silent release
        clear_counts();
        press(32, 10);
        check_counts("long", 0, 0, 1, 2);

        // Second rise exactly on the window boundary
        clear_counts();
        press(3, 8);
        press(3, 12);
        check_counts("win_edge", 0, 1, 0, 0);

        // Second rise one cycle past the window
        clear_counts();
        press(3, 9);
        press(3, 12);
        check_counts("win_late", 2, 0, 0, 0);

        // Reset during a long press with the key still down
        press(25, 0);
        check("pre_rst_held", 32'(key_held), 32'(1));
        do_reset(1'b1);
        clear_counts();
        press(25, 10);
        check_counts("rst_long", 0, 0, 1, 0);

        // Random key traffic, levels at least 4 cycles wide
        clear_counts();
        for (int i = 0; i < 80; i++) begin
            int hi, lo;
            hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(18, 40)) : int'($urandom_range(4, 12));
            lo = int'($urandom_range(4, 14));
            press(hi, lo);
        end
        repeat (12) tick(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_detect.md
KEY_EVENT_DETECT -- requirements
Module: key_event_detect

Parameters
REQ-001 LONG_CYC, 50_000_000, press duration in sys_clk cycles that qualifies as a long press (1 s at 50 MHz).
REQ-002 DBL_CYC, 15_000_000, cycles to wait after a release for a second press (300 ms).
REQ-003 REPEAT_CYC, 10_000_000, auto-repeat period while in long press (200 ms).
REQ-004 CNT_W, 26, counter width; SHALL hold max(LONG_CYC, DBL_CYC, REPEAT_CYC)-1; all *_CYC SHALL be >= 2.

Interface
REQ-005 sys_clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-006 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key_in  input  1  de-glitched key level from the upstream filter stage, synchronous to sys_clk; 1 = pressed.
REQ-008 short_press  output  1  one-cycle pulse: single press released before LONG_CYC, no second press within DBL_CYC.
REQ-009 double_click  output  1  one-cycle pulse: second press released within the double-click window.
REQ-010 long_press  output  1  one-cycle pulse: press held LONG_CYC cycles.
REQ-011 repeat_pulse  output  1  one-cycle pulse every REPEAT_CYC cycles while a long press continues.
REQ-012 key_held  output  1  level, high while the FSM is in LONG.

Function
REQ-013 key_d SHALL register key_in once; rise = key_in & ~key_d, fall = ~key_in & key_d; no extra synchronizer (input already synchronous).
REQ-014 Edge R / edge F denote the clock edge at which rise / fall is true.
REQ-015 FSM states SHALL be IDLE, PRESS1, WAIT2, PRESS2, LONG; one shared counter cnt (CNT_W bits) plus repeat counter rcnt (CNT_W bits).
REQ-016 IDLE: on rise -> PRESS1, cnt <= 0; otherwise stay.
REQ-017 PRESS1: cnt increments each edge; on fall -> WAIT2, cnt <= 0; else when cnt == LONG_CYC-1 -> LONG, long_press pulse, rcnt <= 0.
REQ-018 long_press SHALL therefore be high during the cycle following edge R+LONG_CYC.
REQ-019 WAIT2: cnt increments; on rise -> PRESS2; else when cnt == DBL_CYC-1 -> IDLE, short_press pulse (high during cycle following edge F+DBL_CYC).
REQ-020 WAIT2 boundary: rise and timeout on the same edge (rise at F+DBL_CYC) -> rise wins, PRESS2, no short_press.
REQ-021 PRESS2: on fall -> IDLE, double_click pulse in the following cycle; no long-press detection in PRESS2, any hold duration allowed.
REQ-022 LONG: key_held = 1; rcnt increments; when rcnt == REPEAT_CYC-1, repeat_pulse and rcnt <= 0; on fall -> IDLE, no pulse emitted, key_held low from the following cycle.
REQ-023 Fall at the edge where a repeat would fire -> fall wins, no repeat_pulse.
REQ-024 Pulses SHALL be registered, exactly one cycle wide, mutually exclusive; at most one event pulse per press sequence plus repeats.
REQ-025 Counters SHALL never wrap: every counting state exits or reloads at its terminal value.

Reset
REQ-026 sys_rst_n low SHALL immediately force state IDLE, cnt = 0, rcnt = 0, key_d = 0, all outputs 0.
REQ-027 Reset mid-operation discards the sequence in progress; no pulse on reset entry or exit.
REQ-028 key_in high at reset release -> rise at first edge (key_d = 0), sequence starts in PRESS1; matches upstream filter output reset of 0.

Verification (LONG_CYC=20, DBL_CYC=8, REPEAT_CYC=5, CNT_W=5)
REQ-029 Press 5 cycles, release -> short_press single pulse after edge F+8; no other outputs.
REQ-030 Press 3, release 4, press 3, release -> double_click one pulse after second edge F; no short_press.
REQ-031 Hold 32 cycles -> long_press after R+20; key_held high R+20 until F; repeat_pulse after R+25, R+30; nothing on release.
REQ-032 Window boundary: second rise at F+8 -> double_click, no short_press; second rise at F+9 -> short_press after F+8, then new PRESS1.
REQ-033 Reset asserted in LONG with key_in held high -> outputs 0 asynchronously; after release long_press 20 edges after first edge.
REQ-034 Randomised key_in with min level width 4 cycles -> outputs one-hot per cycle, every pulse 1 cycle wide.
